// File: rtl/down_timer.sv
// Loadable down-counting timer / frequency divider with one-shot and periodic modes.
// tc pulses when a running count is found at zero; div_out toggles on every tc.
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             div_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             tc_reg, tc_next;
    logic             div_reg, div_next;

    // Command priority: load > stop > start > counting. tc defaults low so it
    // can only ever be a single-cycle pulse unless a periodic N=0 re-arms it.
    always_comb begin
        state_next  = state_reg;
        q_next      = q_reg;
        reload_next = reload_reg;
        tc_next     = 1'b0;
        div_next    = div_reg;
        if (load) begin
            reload_next = load_val;
            q_next      = load_val;
            state_next  = IDLE;
        end else if (stop) begin
            state_next = IDLE;
        end else if (start && state_reg != RUN) begin
            if (state_reg == DONE) begin
                q_next = reload_reg;
            end
            state_next = RUN;
        end else if (state_reg == RUN) begin
            // Zero test comes before the decrement, so the count never wraps.
            if (q_reg == '0) begin
                tc_next  = 1'b1;
                div_next = ~div_reg;
                if (auto_reload) begin
                    q_next = reload_reg;
                end else begin
                    state_next = DONE;
                end
            end else begin
                q_next = q_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            q_reg      <= '0;
            reload_reg <= '0;
            tc_reg     <= 1'b0;
            div_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            q_reg      <= q_next;
            reload_reg <= reload_next;
            tc_reg     <= tc_next;
            div_reg    <= div_next;
        end
    end

    assign q       = q_reg;
    assign tc      = tc_reg;
    assign div_out = div_reg;
    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: stimulus pushes model predictions, a monitor
// pops and compares them one clock later against the registered outputs.
module tb_down_timer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         auto_reload;
    logic [W-1:0] q;
    logic         tc;
    logic         div_out;
    logic         busy;
    logic         done;

    down_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .q           (q),
        .tc          (tc),
        .div_out     (div_out),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output word: {q, tc, div_out, busy, done}
    typedef logic [W+3:0] exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_tc     = 0;
    int txn      = 0;

    // Reference model: timer described by its mode and counts as plain ints.
    typedef enum int {M_IDLE, M_RUN, M_DONE} mode_t;
    mode_t m_mode;
    int    m_count;
    int    m_reload;
    int    m_pulse;
    int    m_wave;

    function automatic void model_reset();
        m_mode   = M_IDLE;
        m_count  = 0;
        m_reload = 0;
        m_pulse  = 0;
        m_wave   = 0;
    endfunction

    function automatic exp_t model_step(input int ld, input int lv, input int st,
                                        input int sp, input int ar);
        exp_t e;
        m_pulse = 0;
        if (ld != 0) begin
            m_reload = lv;
            m_count  = lv;
            m_mode   = M_IDLE;
        end else if (sp != 0) begin
            m_mode = M_IDLE;
        end else if (st != 0 && m_mode != M_RUN) begin
            if (m_mode == M_DONE) m_count = m_reload;
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (m_count > 0) begin
                m_count = m_count - 1;
            end else begin
                m_pulse = 1;
                m_wave  = 1 - m_wave;
                if (ar != 0) m_count = m_reload;
                else         m_mode  = M_DONE;
            end
        end
        e = {m_count[W-1:0], m_pulse[0], m_wave[0],
             (m_mode == M_RUN), (m_mode == M_DONE)};
        return e;
    endfunction

    // One clock of stimulus: drive at the falling edge, predict, queue.
    task automatic cycle(input logic ld, input logic [W-1:0] lv, input logic st,
                         input logic sp, input logic ar);
        @(negedge clk);
        load        = ld;
        load_val    = lv;
        start       = st;
        stop        = sp;
        auto_reload = ar;
        exp_q.push_back(model_step(int'(ld), int'(lv), int'(st), int'(sp), int'(ar)));
    endtask

    task automatic idle(input int n, input logic ar);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, ar);
    endtask

    task automatic check_reset_outputs(input string name);
        exp_t got;
        got = {q, tc, div_out, busy, done};
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL %s: got q=%0h tc=%b div=%b busy=%b done=%b, required all zero",
                     name, q, tc, div_out, busy, done);
        end else begin
            $display("txn reset %s: outputs cleared", name);
        end
    endtask

    // Async reset between clock edges, then one idle cycle queued for the next edge.
    task automatic mid_reset();
        @(negedge clk);
        load = 1'b0; start = 1'b0; stop = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_mid_run");
        model_reset();
        #1 rst = 1'b1;
        exp_q.push_back(model_step(0, 0, 0, 0, int'(auto_reload)));
    endtask

    // Monitor
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {q, tc, div_out, busy, done};
                n_checks++;
                txn++;
                if (tc === 1'b1) n_tc++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL txn %0d outputs: got q=%0h tc=%b div=%b busy=%b done=%b, required q=%0h tc=%b div=%b busy=%b done=%b",
                             txn, got[W+3:4], got[3], got[2], got[1], got[0],
                             e[W+3:4], e[3], e[2], e[1], e[0]);
                end else begin
                    $display("txn %0d q=%0h tc=%b div=%b busy=%b done=%b", txn,
                             got[W+3:4], got[3], got[2], got[1], got[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        logic ar;
        load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
        model_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 check_reset_outputs("power_on");
        @(negedge clk);
        #2 rst = 1'b1;

        // One-shot, N=5
        cycle(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(9, 1'b0);

        // Periodic, N=3: 10 pulses in the 40 cycles after the start edge
        cycle(1'b1, 8'd3, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        n_tc = 0;
        idle(41, 1'b1);
        n_checks++;
        if (n_tc != 10) begin
            n_fail++;
            $display("FAIL periodic_tc_count: got %0d pulses, required 10", n_tc);
        end else begin
            $display("txn periodic_tc_count: %0d pulses", n_tc);
        end

        // Stop at q=6, hold, resume
        cycle(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(5, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(10, 1'b0);

        // Load+start on the same edge as a running q==0
        cycle(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        cycle(1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Stop on the same edge as q==0 in periodic mode
        cycle(1'b1, 8'd1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // N=0 periodic, then N=0 one-shot
        cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle(8, 1'b1);
        cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);

        // N=0xFF one-shot, no underflow
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(262, 1'b0);

        // Async reset mid-run at q=0x37
        cycle(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(9, 1'b0);
        mid_reset();
        idle(2, 1'b0);

        // Randomized traffic, with auto_reload changing mid-run
        ar = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            logic ld, st, sp;
            logic [W-1:0] lv;
            r  = int'($urandom_range(0, 99));
            ld = (r < 4);
            sp = (r >= 4 && r < 8);
            st = (r >= 8 && r < 22);
            if ($urandom_range(0, 19) == 0) ar = ~ar;
            lv = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            cycle(ld, lv, st, sp, ar);
        end
        idle(3, ar);

        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/down_timer.md
# down_timer

Loadable, programmable down-counting timer and frequency divider; the counterpart to the team's free-running up counter. Counts a programmed value down to zero, raises a one-cycle terminal-count pulse, and either stops (one-shot) or reloads (periodic). A toggle output gives a divided clock-enable/square wave of period 2·(N+1) cycles. Used as the tick and divider source for the lab datapaths.

## Interface

- WIDTH, 8, counter and reload width in bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- load  input  1  load load_val into reload register and counter; forces IDLE
- load_val  input  WIDTH  reload value N
- start  input  1  begin/resume counting
- stop  input  1  halt counting, hold count
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled every cycle
- q  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse (registered)
- div_out  output  1  toggles on every tc (registered)
- busy  output  1  high in RUN
- done  output  1  high in DONE

## Operation

- State registers: state {IDLE, RUN, DONE}, q, reload_reg, tc, div_out.
- Reset (rst=0, asynchronous): state=IDLE, q=0, reload_reg=0, tc=0, div_out=0; hence busy=0, done=0.
- Control priority per edge: load > stop > start > counting.
- load (any state): reload_reg<=load_val, q<=load_val, state<=IDLE, tc<=0; div_out unchanged.
- stop (no load): state<=IDLE, q holds, tc<=0.
- start in IDLE: state<=RUN, q unchanged (resume after stop is supported).
- start in DONE: state<=RUN, q<=reload_reg.
- start in RUN: ignored.
- RUN, q!=0: q<=q-1, tc<=0.
- RUN, q==0: tc<=1, div_out<=~div_out; if auto_reload=1, q<=reload_reg and stay RUN; else state<=DONE, q stays 0.
- IDLE/DONE with no command: q, div_out hold; tc<=0.
- busy = (state==RUN), done = (state==DONE); decoded directly from the state register, no extra latency.
- Arithmetic: unsigned WIDTH-bit. q never decrements below 0; the q==0 check precedes any decrement, so no wrap to all-ones.

## Timing

- Edge E0 samples start with q=N: RUN from E0; q reaches 0 after E_N; tc high for the cycle following E_{N+1}.
- One-shot: tc is a single-cycle pulse; DONE begins at E_{N+1}.
- Periodic: tc pulses every N+1 cycles; div_out period 2·(N+1) cycles, 50% duty.
- N=0 periodic: tc stays high continuously, div_out toggles every cycle.
- N=0 one-shot: tc one cycle after E1, then DONE.
- auto_reload changed mid-run: takes effect at the next q==0 edge only.
- load or stop on the same edge as q==0: load/stop wins, with no tc and no div_out toggle.
- Asynchronous reset mid-count: all outputs clear immediately. Release is synchronous to the next clk edge by the integrator.

## Test plan

- Reset: drive rst=0 mid-RUN with q=0x37 -> q=0, tc=0, div_out=0, busy=0, done=0 immediately, without waiting for a clock edge.
- One-shot: load 5, auto_reload=0, pulse start -> q counts 5,4,3,2,1,0; one tc pulse 6 cycles after the start edge; done=1; q holds 0.
- Periodic: load 3, auto_reload=1, start -> tc every 4 cycles; div_out period 8 cycles; after 40 cycles, 10 tc pulses.
- Stop/resume: load 10, start, stop when q=6 -> q holds 6 for 5 idle cycles; start -> tc exactly 7 cycles later.
- Priority: assert load(val=2) and start together while RUN at q==0 -> q=2, state IDLE, no tc, div_out unchanged.
- Edges: load 0 periodic -> tc constantly 1 and div_out toggling each cycle; load 0xFF one-shot -> tc 256 cycles after start, with no underflow to 0xFF.
